capture_buffer: RTL and testbench
=================================

# capture_buffer

Sample store that sits downstream of the channel trigger in the logic analyzer. While the trigger's run output is high it records one `i_data` word per clock into an on-chip RAM. When the run ends or the RAM fills, it streams the captured words out oldest-first over a valid/ready handshake toward the host link.

## Interface
Parameters:
- `WIDTH`, 8: sample width in bits; must match the trigger's data width.
- `DEPTH`, 256: capture depth in samples; power of two, ≥ 4.
- `ADDR_W`, `$clog2(DEPTH)`: derived; not to be overridden.

Ports:
- `i_clk`  in  1: the single clock for all logic.
- `i_rst`  in  1: reset, asynchronous and active-high.
- `i_data`  in  `WIDTH`: sample input, same bus the trigger watches.
- `i_run`  in  1: capture enable; connected to the trigger's `o_run`.
- `i_arm`  in  1: level; arms a new capture, honoured only in IDLE.
- `o_rd_data`  out  `WIDTH`: readout sample.
- `o_rd_valid`  out  1: `o_rd_data` holds a valid sample.
- `i_rd_ready`  in  1: consumer accepts the sample.
- `o_count`  out  `ADDR_W+1`: number of samples stored in the current or last capture.
- `o_state`  out  2: 0 = IDLE, 1 = ARMED, 2 = CAPTURE, 3 = READOUT.
- `o_full`  out  1: high while `o_count == DEPTH`.
- `o_done`  out  1: one-cycle pulse when the last sample has been transferred.

## Operation
- **IDLE**
  - `i_arm == 1` → ARMED.
  - The write pointer, read pointer and `o_count` clear to 0 on this transition.
- **ARMED**
  - Waits for `i_run == 1`.
  - On the first clock edge with `i_run == 1`: writes `i_data` to address 0, sets `o_count = 1`, and moves to CAPTURE.
  - `i_arm` has no effect here.
- **CAPTURE**
  - Each edge with `i_run == 1` and `o_count < DEPTH` writes `i_data` at address `o_count` and increments `o_count`.
  - Exit to READOUT when `i_run == 0` is sampled, or on the edge where `o_count` becomes `DEPTH`.
  - Samples offered after the RAM is full are dropped.
  - There is no wrap-around and no overwrite.
- **READOUT**
  - Presents addresses 0 … `o_count−1` in order on `o_rd_data` / `o_rd_valid`.
  - A transfer occurs on an edge where `o_rd_valid & i_rd_ready`.
  - While `o_rd_valid == 1` and `i_rd_ready == 0`, `o_rd_data` holds stable and `o_rd_valid` stays high.
  - Sustains one transfer per clock under continuous `i_rd_ready`, using a prefetch/skid register around the synchronous RAM.
  - After the transfer of sample `o_count−1`: `o_rd_valid` drops, `o_done` pulses for one cycle, and the state returns to IDLE.
  - `o_count` retains its value until the next arm.
- **Ignored inputs**
  - `i_run` is ignored in IDLE and READOUT.
  - `i_rd_ready` is ignored outside READOUT.
- **Reset**
  - Any state → IDLE.
  - On reset: `o_rd_valid = 0`, `o_done = 0`, `o_count = 0`, `o_full = 0`, `o_state = 0`, and `o_rd_data = 0`.
  - Reset mid-capture or mid-readout discards the capture; RAM contents are don't-care.

## Timing
- Capture latency is zero: the sample stored is `i_data` as sampled on the same edge that sees `i_run == 1`.
- For a run that is high for N consecutive edges (N ≤ DEPTH), exactly N samples are stored.
- `o_state` changes on the edge following the deciding condition; it is registered and has no combinational path from inputs.
- `o_rd_valid` first asserts exactly 2 clocks after the edge that enters READOUT: one cycle for the RAM address, one for RAM data.
- Back-to-back readout: with `i_rd_ready` held high, sample k transfers on edge T0+k, where T0 is the first valid edge.
- `o_done` is high in the cycle following the final transfer; `o_state` is 0 in that same cycle.
- `o_full` asserts in the cycle after the `DEPTH`-th write.
- A new `i_arm` is accepted no earlier than the cycle in which `o_done` is high.

## Test plan
- **Reset values:** assert `i_rst` asynchronously mid-CAPTURE with `o_count = 5` → all outputs 0 immediately with no clock edge; `o_state = 0`.
- **Basic capture:** arm, then drive `i_run` high for 4 edges with `i_data` = 0x11, 0x22, 0x33, 0x44; `i_rd_ready` held high → `o_count = 4`; readout 0x11, 0x22, 0x33, 0x44 on consecutive cycles; `o_done` pulses once; state returns to 0.
- **Overflow (`DEPTH = 8`):** `i_run` high for 12 edges with an incrementing pattern 0…11 → `o_full = 1`, `o_count = 8`; readout is 0…7 only.
- **Back-pressure:** 3 stored samples; `i_rd_ready` pattern 0, 0, 1, 0, 1, 1 → `o_rd_data` stable while stalled; exactly 3 transfers, in order; no duplicates or skips.
- **Ignored inputs:** `i_arm` pulsed during CAPTURE and READOUT, and `i_run` toggled during READOUT → no state change, `o_count` unchanged, readout unaffected.
- **Single-sample run:** `i_run` high for 1 edge → `o_count = 1`; one transfer; `o_done` follows it.

Source files
------------

// File: rtl/capture_buffer.sv
// capture_buffer: records i_data while i_run is high into an on-chip RAM,
// then streams the captured words out oldest-first over valid/ready.
// The readout path is a two-stage pipeline: a stallable RAM output register
// followed by the output register, so one transfer per clock is sustained.
module capture_buffer #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [WIDTH-1:0]  i_data,
    input  logic              i_run,
    input  logic              i_arm,
    output logic [WIDTH-1:0]  o_rd_data,
    output logic              o_rd_valid,
    input  logic              i_rd_ready,
    output logic [ADDR_W:0]   o_count,
    output logic [1:0]        o_state,
    output logic              o_full,
    output logic              o_done
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_ARMED   = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;
    localparam logic [1:0] S_READOUT = 2'd3;

    localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] C_ONE   = (ADDR_W+1)'(1);

    // Sample storage and RAM read register (no reset: contents are don't-care)
    logic [WIDTH-1:0]  r_mem [DEPTH];
    logic [WIDTH-1:0]  r_ram_q;

    logic [1:0]        r_state;
    logic [ADDR_W:0]   r_count;
    logic [ADDR_W:0]   r_rd_ptr;     // next address to fetch from RAM
    logic              r_full;
    logic              r_q_valid;    // r_ram_q holds a fetched, unconsumed sample
    logic [WIDTH-1:0]  r_rd_data;
    logic              r_rd_valid;
    logic              r_done;

    logic              w_wr_en;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [ADDR_W:0]   w_count_inc;
    logic              w_in_readout;
    logic              w_out_ready;
    logic              w_load;
    logic              w_fetch;
    logic              w_xfer;
    logic              w_last;

    assign w_count_inc  = r_count + C_ONE;
    assign w_in_readout = (r_state == S_READOUT);
    // Output register can accept a new word when empty or being drained
    assign w_out_ready  = ~r_rd_valid | i_rd_ready;
    assign w_load       = w_in_readout & r_q_valid & w_out_ready;
    // Fetch when words remain and the RAM register is free or moving on
    assign w_fetch      = w_in_readout & (r_rd_ptr < r_count) & (~r_q_valid | w_out_ready);
    assign w_xfer       = w_in_readout & r_rd_valid & i_rd_ready;
    // Final transfer: nothing in flight and every stored word already fetched
    assign w_last       = w_xfer & ~r_q_valid & (r_rd_ptr == r_count);

    // Write-port decode: first sample lands at 0, later ones at the running count
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_addr = '0;
        case (r_state)
            S_ARMED: begin
                w_wr_en   = i_run;
                w_wr_addr = '0;
            end
            S_CAPTURE: begin
                w_wr_en   = i_run;
                w_wr_addr = r_count[ADDR_W-1:0];
            end
            default: begin
                w_wr_en   = 1'b0;
                w_wr_addr = '0;
            end
        endcase
    end

    // RAM write port
    always_ff @(posedge i_clk) begin
        if (w_wr_en) begin
            r_mem[w_wr_addr] <= i_data;
        end
    end

    // RAM synchronous read port, held while the next stage is stalled
    always_ff @(posedge i_clk) begin
        if (w_fetch) begin
            r_ram_q <= r_mem[r_rd_ptr[ADDR_W-1:0]];
        end
    end

    // Capture/readout sequencing, sample count and full flag
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_full   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_last;
            case (r_state)
                S_IDLE: begin
                    if (i_arm) begin
                        r_state  <= S_ARMED;
                        r_count  <= '0;
                        r_rd_ptr <= '0;
                        r_full   <= 1'b0;
                    end
                end
                S_ARMED: begin
                    if (i_run) begin
                        r_count <= C_ONE;
                        r_state <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (i_run) begin
                        r_count <= w_count_inc;
                        if (w_count_inc == C_DEPTH) begin
                            r_state <= S_READOUT;
                            r_full  <= 1'b1;
                        end
                    end else begin
                        r_state <= S_READOUT;
                    end
                end
                S_READOUT: begin
                    if (w_fetch) begin
                        r_rd_ptr <= r_rd_ptr + C_ONE;
                    end
                    if (w_last) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Readout pipeline occupancy and output register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_q_valid  <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            if (w_fetch) begin
                r_q_valid <= 1'b1;
            end else if (w_load) begin
                r_q_valid <= 1'b0;
            end

            if (w_load) begin
                r_rd_data  <= r_ram_q;
                r_rd_valid <= 1'b1;
            end else if (w_xfer) begin
                r_rd_valid <= 1'b0;
            end
        end
    end

    assign o_rd_data  = r_rd_data;
    assign o_rd_valid = r_rd_valid;
    assign o_count    = r_count;
    assign o_state    = r_state;
    assign o_full     = r_full;
    assign o_done     = r_done;

endmodule

// File: tb/tb_capture_buffer.sv
// Self-checking bench for capture_buffer (DEPTH = 8). The reference model is a
// queue of the samples that should survive a run (the first min(N, DEPTH)
// offered), drained in order as the bench observes handshakes.
module tb_capture_buffer;

    localparam int WIDTH  = 8;
    localparam int DEPTH  = 8;
    localparam int ADDR_W = 3;

    logic              i_clk;
    logic              i_rst;
    logic [WIDTH-1:0]  i_data;
    logic              i_run;
    logic              i_arm;
    logic [WIDTH-1:0]  o_rd_data;
    logic              o_rd_valid;
    logic              i_rd_ready;
    logic [ADDR_W:0]   o_count;
    logic [1:0]        o_state;
    logic              o_full;
    logic              o_done;

    int n_checks;
    int n_fail;

    capture_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_data     (i_data),
        .i_run      (i_run),
        .i_arm      (i_arm),
        .o_rd_data  (o_rd_data),
        .o_rd_valid (o_rd_valid),
        .i_rd_ready (i_rd_ready),
        .o_count    (o_count),
        .o_state    (o_state),
        .o_full     (o_full),
        .o_done     (o_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // One full arm / capture / readout cycle.
    // data_mode: 0 random, 1 incrementing from 0, 2 table 11,22,33,44
    // ready_mode: 0 always ready, 1 random, 2 pattern 0,0,1,0,1,1 from first valid
    task automatic run_capture(input int n, input int data_mode, input int ready_mode,
                               input bit noise);
        logic [7:0] send[$];
        logic [7:0] exp_q[$];
        logic [7:0] table4 [4];
        int         pat [6];
        int         exp_cnt;
        int         idx;
        bit         finished;
        int         waits;

        table4 = '{8'h11, 8'h22, 8'h33, 8'h44};
        pat    = '{0, 0, 1, 0, 1, 1};
        for (int k = 0; k < n; k++) begin
            logic [7:0] v;
            case (data_mode)
                1:       v = 8'(k);
                2:       v = table4[k % 4];
                default: v = 8'($urandom);
            endcase
            send.push_back(v);
            if (k < DEPTH) exp_q.push_back(v);
        end
        exp_cnt = (n < DEPTH) ? n : DEPTH;

        // Arm
        i_arm = 1'b1; i_run = 1'b0; i_rd_ready = 1'b0;
        tick();
        i_arm = 1'b0;
        check("arm_state", o_state, 1);
        check("arm_count", o_count, 0);
        check("arm_full", o_full, 0);
        waits = $urandom_range(0, 2);
        for (int w = 0; w < waits; w++) begin
            i_data = 8'($urandom);
            i_rd_ready = 1'($urandom_range(0, 1));
            tick();
            check("armed_wait", o_state, 1);
        end

        // Capture: run high for consecutive edges until done or RAM full
        for (int k = 0; k < n && k < DEPTH; k++) begin
            i_run  = 1'b1;
            i_data = send[k];
            i_arm  = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            check("cap_count", o_count, k + 1);
            check("cap_full", o_full, (k + 1 == DEPTH) ? 1 : 0);
            check("cap_state", o_state, (k + 1 == DEPTH) ? 3 : 2);
        end
        i_arm = 1'b0;
        if (n < DEPTH) begin
            i_run  = 1'b0;
            i_data = 8'($urandom);
            tick();
            check("exit_state", o_state, 3);
            check("exit_count", o_count, n);
        end

        // Readout; 'it' counts cycles after the edge that entered READOUT
        idx = 0;
        finished = 1'b0;
        for (int it = 0; it < 200 && !finished; it++) begin
            if (it < 2)  check("lat_valid_lo", o_rd_valid, 0);
            if (it == 2) check("lat_valid_hi", o_rd_valid, 1);
            if (ready_mode == 0 && it >= 2) check("b2b_valid", o_rd_valid, 1);
            check("ro_state", o_state, 3);
            check("ro_count", o_count, exp_cnt);
            check("ro_done", o_done, 0);

            if (it < n - DEPTH) begin
                i_run  = 1'b1;
                i_data = send[DEPTH + it];
            end else begin
                i_run  = 1'($urandom_range(0, 1));
                i_data = 8'($urandom);
            end
            i_arm = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            case (ready_mode)
                0:       i_rd_ready = 1'b1;
                1:       i_rd_ready = 1'($urandom_range(0, 1));
                2:       i_rd_ready = (it >= 2 && it - 2 < 6) ? 1'(pat[it - 2]) :
                                      ((it < 2) ? 1'b0 : 1'b1);
                default: i_rd_ready = 1'b1;
            endcase

            if (o_rd_valid) begin
                if (idx < exp_cnt) begin
                    check("rd_data", o_rd_data, exp_q[idx]);
                end else begin
                    check("extra_valid", o_rd_valid, 0);
                end
                if (i_rd_ready) begin
                    idx++;
                    if (idx >= exp_cnt) finished = 1'b1;
                end
            end
            tick();
        end
        i_run = 1'b0; i_arm = 1'b0; i_rd_ready = 1'b0;

        check("xfer_total", idx, exp_cnt);
        check("done_pulse", o_done, 1);
        check("done_state", o_state, 0);
        check("done_valid", o_rd_valid, 0);
        check("done_count", o_count, exp_cnt);
        check("done_full", o_full, (exp_cnt == DEPTH) ? 1 : 0);
        tick();
        check("done_clear", o_done, 0);
        check("idle_state", o_state, 0);
        check("idle_count", o_count, exp_cnt);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        i_rst = 1'b1; i_data = '0; i_run = 1'b0; i_arm = 1'b0; i_rd_ready = 1'b0;
        #12;
        check("por_state", o_state, 0);
        check("por_count", o_count, 0);
        check("por_full", o_full, 0);
        check("por_valid", o_rd_valid, 0);
        check("por_done", o_done, 0);
        check("por_data", o_rd_data, 0);
        @(negedge i_clk);
        i_rst = 1'b0;
        tick();
        check("idle_hold", o_state, 0);

        run_capture(4, 2, 0, 1'b0);     // basic table, continuous ready
        run_capture(12, 1, 0, 1'b0);    // overflow: 0..11 offered, 0..7 kept
        run_capture(3, 0, 2, 1'b0);     // back-pressure pattern
        run_capture(1, 0, 0, 1'b0);     // single sample
        run_capture(5, 0, 1, 1'b1);     // arm/run noise during capture and readout
        for (int r = 0; r < 6; r++) begin
            run_capture($urandom_range(1, 11), 0, 1, 1'($urandom_range(0, 1)));
        end

        // Asynchronous reset in the middle of a capture with 5 samples stored
        i_arm = 1'b1;
        tick();
        i_arm = 1'b0;
        for (int k = 0; k < 5; k++) begin
            i_run  = 1'b1;
            i_data = 8'($urandom);
            tick();
        end
        check("pre_rst_count", o_count, 5);
        check("pre_rst_state", o_state, 2);
        #2;
        i_rst = 1'b1;
        #1;
        check("rst_state", o_state, 0);
        check("rst_count", o_count, 0);
        check("rst_full", o_full, 0);
        check("rst_valid", o_rd_valid, 0);
        check("rst_done", o_done, 0);
        check("rst_data", o_rd_data, 0);
        i_run = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b0;
        tick();
        check("post_rst_state", o_state, 0);

        run_capture(2, 0, 0, 1'b0);     // recovers after reset

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
